// File: rtl/engine_alu_ops_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module   : engine_alu_ops_collector_pkg
// Brief    : Shared packet type, FSM encoding and count width for the collector.
// Revision : 1.0
// ============================================================================
package engine_alu_ops_collector_pkg;

    localparam int ALU_OPS_COLLECTOR_COUNT_W = 32;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  tag;
        logic [47:0] value;
    } EnginePacketData;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } engine_alu_ops_collector_state_e;

endpackage
`default_nettype wire

// File: rtl/engine_alu_ops_collector_fifo.sv
`default_nettype none
// ============================================================================
// Module   : engine_alu_ops_collector_fifo
// Brief    : Result buffer with a registered output stage; occupancy counts
//            both the storage array and the output register.
// Revision : 1.0
// ============================================================================
module engine_alu_ops_collector_fifo
    import engine_alu_ops_collector_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  EnginePacketData          push_data,
    input  logic                     out_ready,
    output logic                     out_valid,
    output EnginePacketData          out_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [$clog2(DEPTH):0]   occupancy_next
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    EnginePacketData    mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   mem_count;
    logic [OCC_W-1:0]   mem_count_next;
    logic               pop;
    logic               load;

    assign pop  = out_valid && out_ready;
    // Output register refills from storage whenever it is empty or being consumed.
    assign load = (mem_count != '0) && (!out_valid || out_ready);
    assign full = (occupancy == OCC_FULL);

    always_comb begin
        mem_count_next = mem_count;
        if (push && !load) begin
            mem_count_next = mem_count + OCC_ONE;
        end else if (!push && load) begin
            mem_count_next = mem_count - OCC_ONE;
        end
    end

    always_comb begin
        occupancy_next = occupancy;
        if (push && !pop) begin
            occupancy_next = occupancy + OCC_ONE;
        end else if (!push && pop) begin
            occupancy_next = occupancy - OCC_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            occupancy <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            occupancy <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (load) begin
                rd_ptr    <= rd_ptr + PTR_ONE;
                out_valid <= 1'b1;
                out_data  <= mem[rd_ptr];
            end else if (pop) begin
                out_valid <= 1'b0;
            end
            mem_count <= mem_count_next;
            occupancy <= occupancy_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/engine_alu_ops_collector.sv
`default_nettype none
// ============================================================================
// Module   : engine_alu_ops_collector
// Brief    : Collects a fixed number of ALU kernel results into a buffer and
//            streams them downstream. Build option: ENGINE_ALU_OPS_COLLECTOR_STATS_EN
//            exports live accepted/dropped counters.
// Revision : 1.0
// ============================================================================
module engine_alu_ops_collector
    import engine_alu_ops_collector_pkg::*;
#(
    parameter int FIFO_DEPTH   = 16,
    parameter int STALL_MARGIN = 4
) (
    input  logic                                  ap_clk,
    input  logic                                  areset_n,
    input  logic                                  clear,
    input  logic                                  start_valid,
    input  logic [ALU_OPS_COLLECTOR_COUNT_W-1:0]  expected_count,
    input  logic                                  in_result_flag,
    input  EnginePacketData                       in_result,
    output logic                                  stall_upstream,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output EnginePacketData                       out_data,
    output logic                                  done,
    output logic                                  overflow,
    output logic                                  unexpected,
    output logic [ALU_OPS_COLLECTOR_COUNT_W-1:0]  stat_accepted,
    output logic [ALU_OPS_COLLECTOR_COUNT_W-1:0]  stat_dropped
);

    localparam int CNT_W = ALU_OPS_COLLECTOR_COUNT_W;
    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [OCC_W-1:0] STALL_THRESH = OCC_W'(FIFO_DEPTH - STALL_MARGIN);

    if (FIFO_DEPTH < 8 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 8");
    end

    engine_alu_ops_collector_state_e state;
    engine_alu_ops_collector_state_e state_next;

    logic [CNT_W-1:0]  expected_lat;
    logic [CNT_W-1:0]  collected;
    logic              full;
    logic [OCC_W-1:0]  occupancy;
    logic [OCC_W-1:0]  occupancy_next;
    logic              pop;
    logic              in_collect;
    logic              accept;
    logic              drop;
    logic              stray;
    logic              last_event;
    logic              start_ok;

    assign pop        = out_valid && out_ready;
    assign in_collect = (state == ST_COLLECT);
    assign accept     = in_result_flag && in_collect && (!full || pop);
    assign drop       = in_result_flag && in_collect && full && !pop;
    assign stray      = in_result_flag && !in_collect;
    // Drops count toward completion so a lossy run still terminates.
    assign last_event = (accept || drop) && ((collected + CNT_ONE) == expected_lat);
    assign start_ok   = (state == ST_IDLE) && start_valid && !clear;

    engine_alu_ops_collector_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk            (ap_clk),
        .rst_n          (areset_n),
        .flush          (clear),
        .push           (accept),
        .push_data      (in_result),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .full           (full),
        .occupancy      (occupancy),
        .occupancy_next (occupancy_next)
    );

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_valid) begin
                        state_next = (expected_count == '0) ? ST_DONE : ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (last_event) begin
                        state_next = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (occupancy == '0 && !out_valid) begin
                        state_next = ST_DONE;
                    end
                end
                ST_DONE:  state_next = ST_DONE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge ap_clk or negedge areset_n) begin
        if (!areset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge ap_clk or negedge areset_n) begin
        if (!areset_n) begin
            expected_lat   <= '0;
            collected      <= '0;
            done           <= 1'b0;
            overflow       <= 1'b0;
            unexpected     <= 1'b0;
            stall_upstream <= 1'b0;
        end else if (clear) begin
            expected_lat   <= '0;
            collected      <= '0;
            done           <= 1'b0;
            overflow       <= 1'b0;
            unexpected     <= 1'b0;
            stall_upstream <= 1'b0;
        end else begin
            if (start_ok) begin
                expected_lat <= expected_count;
                collected    <= '0;
            end else if (accept || drop) begin
                collected <= collected + CNT_ONE;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (stray) begin
                unexpected <= 1'b1;
            end
            done           <= (state_next == ST_DONE);
            stall_upstream <= (occupancy_next >= STALL_THRESH);
        end
    end

`ifdef ENGINE_ALU_OPS_COLLECTOR_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] accepted_cnt;
    logic [CNT_W-1:0] dropped_cnt;

    always_ff @(posedge ap_clk or negedge areset_n) begin
        if (!areset_n) begin
            accepted_cnt <= '0;
            dropped_cnt  <= '0;
        end else if (clear || start_ok) begin
            accepted_cnt <= '0;
            dropped_cnt  <= '0;
        end else begin
            if (accept && accepted_cnt != CNT_MAX) begin
                accepted_cnt <= accepted_cnt + CNT_ONE;
            end
            if (drop && dropped_cnt != CNT_MAX) begin
                dropped_cnt <= dropped_cnt + CNT_ONE;
            end
        end
    end

    assign stat_accepted = accepted_cnt;
    assign stat_dropped  = dropped_cnt;
`else
    assign stat_accepted = '0;
    assign stat_dropped  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_engine_alu_ops_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_engine_alu_ops_collector
// Brief    : Randomized bench with a cycle-level reference model and a
//            scoreboard queue of expected output packets.
// Revision : 1.0
// ============================================================================
module tb_engine_alu_ops_collector;
    import engine_alu_ops_collector_pkg::*;

    localparam int DEPTH   = 16;
    localparam int MARGIN  = 4;
    localparam int MAX_CYC = 60000;

    logic            ap_clk = 1'b0;
    logic            areset_n = 1'b0;
    logic            clear = 1'b0;
    logic            start_valid = 1'b0;
    logic [31:0]     expected_count = '0;
    logic            in_result_flag = 1'b0;
    EnginePacketData in_result = '0;
    logic            out_ready = 1'b0;
    logic            stall_upstream;
    logic            out_valid;
    EnginePacketData out_data;
    logic            done;
    logic            overflow;
    logic            unexpected;
    logic [31:0]     stat_accepted;
    logic [31:0]     stat_dropped;

    engine_alu_ops_collector #(
        .FIFO_DEPTH   (DEPTH),
        .STALL_MARGIN (MARGIN)
    ) dut (
        .ap_clk         (ap_clk),
        .areset_n       (areset_n),
        .clear          (clear),
        .start_valid    (start_valid),
        .expected_count (expected_count),
        .in_result_flag (in_result_flag),
        .in_result      (in_result),
        .stall_upstream (stall_upstream),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .done           (done),
        .overflow       (overflow),
        .unexpected     (unexpected),
        .stat_accepted  (stat_accepted),
        .stat_dropped   (stat_dropped)
    );

    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: phase 0 idle, 1 collect, 2 drain, 3 done.
    int              m_phase = 0;
    longint          m_expected = 0;
    longint          m_seen = 0;
    longint          m_acc = 0;
    longint          m_drop = 0;
    bit              m_over = 0;
    bit              m_unexp = 0;
    bit              m_done = 0;
    bit              m_stall = 0;
    int              cyc = 0;
    int              mq[$];        // cycle from which each buffered result is visible
    EnginePacketData exp_q[$];

    function automatic void model_reset();
        m_phase = 0; m_expected = 0; m_seen = 0; m_acc = 0; m_drop = 0;
        m_over = 0; m_unexp = 0; m_done = 0; m_stall = 0;
        mq.delete();
        exp_q.delete();
    endfunction

    function automatic bit model_visible();
        return (mq.size() > 0) && (cyc >= mq[0]);
    endfunction

    initial begin
        forever begin
            @(negedge ap_clk);
            if (!areset_n) model_reset();
            chk("out_valid", out_valid, model_visible());
            chk("done", done, m_done);
            chk("overflow", overflow, m_over);
            chk("unexpected", unexpected, m_unexp);
            chk("stall_upstream", stall_upstream, m_stall);
`ifdef ENGINE_ALU_OPS_COLLECTOR_STATS_EN
            chk("stat_accepted", stat_accepted, 64'(m_acc));
            chk("stat_dropped", stat_dropped, 64'(m_drop));
`else
            chk("stat_accepted", stat_accepted, 64'd0);
            chk("stat_dropped", stat_dropped, 64'd0);
`endif
            if (!areset_n) begin
                chk("reset_out_data", out_data, 64'd0);
            end else if (clear) begin
                model_reset();
            end else begin
                int occ;
                bit pop, acc, drp;
                occ = mq.size();
                pop = model_visible() && out_ready;
                acc = 0;
                drp = 0;
                if (in_result_flag) begin
                    if (m_phase == 1) begin
                        if (occ < DEPTH || pop) acc = 1;
                        else drp = 1;
                    end else begin
                        m_unexp = 1;
                    end
                end
                if (pop) void'(mq.pop_front());
                if (acc) begin
                    mq.push_back(cyc + 2);
                    exp_q.push_back(in_result);
                    if (m_acc < 64'hFFFF_FFFF) m_acc++;
                end
                if (drp) begin
                    m_over = 1;
                    if (m_drop < 64'hFFFF_FFFF) m_drop++;
                end
                case (m_phase)
                    0: if (start_valid) begin
                        m_expected = expected_count;
                        m_seen = 0; m_acc = 0; m_drop = 0;
                        m_phase = (expected_count == 0) ? 3 : 1;
                    end
                    1: if (acc || drp) begin
                        m_seen++;
                        if (m_seen == m_expected) m_phase = 2;
                    end
                    2: if (occ == 0) m_phase = 3;
                    default: ;
                endcase
                m_done  = (m_phase == 3);
                m_stall = (mq.size() >= DEPTH - MARGIN);
            end
            cyc++;
        end
    end

    // Monitor: compares every handshake against the scoreboard and checks hold stability.
    initial begin
        EnginePacketData held;
        bit hold;
        held = '0;
        hold = 0;
        forever begin
            @(negedge ap_clk);
            if (!areset_n || clear) begin
                hold = 0;
            end else begin
                if (hold && out_valid) chk("out_data_hold", out_data, held);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) chk("output_without_expectation", 64'(exp_q.size()), 64'd1);
                    else chk("out_data", out_data, exp_q.pop_front());
                end
                hold = out_valid && !out_ready;
                held = out_data;
            end
        end
    end

    initial begin
        #(MAX_CYC * 10);
        $display("FAIL watchdog: simulation did not finish within %0d cycles", MAX_CYC);
        $fatal(1);
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start_valid = 1'b1;
        expected_count = 32'(n);
        tick();
        start_valid = 1'b0;
    endtask

    task automatic push_flags(input int n);
        for (int i = 0; i < n; i++) begin
            in_result_flag = 1'b1;
            in_result = {$urandom, $urandom};
            tick();
        end
        in_result_flag = 1'b0;
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rand_ready);
        int k;
        k = 0;
        while (!done && k < budget) begin
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
            tick();
            k++;
        end
        chk("done_reached", done, 1'b1);
    endtask

    initial begin
        repeat (3) tick();
        areset_n = 1'b1;
        tick();

        // Basic run of five results with a ready sink
        out_ready = 1'b1;
        do_start(5);
        push_flags(5);
        wait_done(50, 0);
`ifdef ENGINE_ALU_OPS_COLLECTOR_STATS_EN
        chk("basic_stat_accepted", stat_accepted, 64'd5);
`endif
        clear_pulse();
        chk("clear_from_done", done, 1'b0);

        // Backpressure: fill, stall, overflow, then drain
        out_ready = 1'b0;
        do_start(20);
        push_flags(20);
        tick();
        chk("bp_overflow", overflow, 1'b1);
        chk("bp_stall", stall_upstream, 1'b1);
`ifdef ENGINE_ALU_OPS_COLLECTOR_STATS_EN
        chk("bp_accepted", stat_accepted, 64'd16);
        chk("bp_dropped", stat_dropped, 64'd4);
`endif
        repeat (5) tick();
        chk("bp_still_draining", done, 1'b0);
        out_ready = 1'b1;
        wait_done(100, 0);
        clear_pulse();

        // Full buffer with simultaneous push and pop
        out_ready = 1'b0;
        do_start(40);
        push_flags(16);
        out_ready = 1'b1;
        push_flags(10);
        chk("full_pushpop_no_overflow", overflow, 1'b0);
        for (int k = 0; k < 100 && m_phase == 1; k++) begin
            in_result_flag = 1'b1;
            in_result = {$urandom, $urandom};
            tick();
        end
        in_result_flag = 1'b0;
        wait_done(100, 0);
        clear_pulse();

        // Zero count completes immediately
        do_start(0);
        chk("zero_count_done", done, 1'b1);
        clear_pulse();

        // Stray result in IDLE
        in_result_flag = 1'b1;
        in_result = {$urandom, $urandom};
        tick();
        in_result_flag = 1'b0;
        chk("stray_unexpected", unexpected, 1'b1);
        chk("stray_not_counted", stat_accepted, 64'd0);
        clear_pulse();

        // Asynchronous reset with seven buffered entries
        out_ready = 1'b0;
        do_start(10);
        push_flags(7);
        tick();
        chk("pre_reset_valid", out_valid, 1'b1);
        #2;
        areset_n = 1'b0;
        #1;
        chk("async_reset_out_valid", out_valid, 1'b0);
        chk("async_reset_out_data", out_data, 64'd0);
        @(posedge ap_clk);
        #1;
        areset_n = 1'b1;
        out_ready = 1'b1;
        repeat (10) tick();

        // Randomized collections with random sink readiness
        for (int r = 0; r < 12; r++) begin
            do_start($urandom_range(1, 30));
            for (int k = 0; k < 400 && m_phase == 1; k++) begin
                in_result_flag = ($urandom_range(0, 2) != 0);
                in_result = {$urandom, $urandom};
                out_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
            in_result_flag = 1'b0;
            wait_done(200, 1);
            if ($urandom_range(0, 1) == 1) begin
                in_result_flag = 1'b1;
                tick();
                in_result_flag = 1'b0;
            end
            clear_pulse();
        end

        repeat (2) tick();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
